// File: rtl/mcycle_unit.sv
// Multi-cycle multiply/divide unit beside the ALU in the execute stage.
// One shift-add or restoring-subtract step per clock; Busy stalls the pipe.
module mcycle_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Start,
   input  logic [1:0]       MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy,
   output logic             Done
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      COMPUTING,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   raw1_q, raw1_d;
   logic               neg_q, neg_d;
   logic               rsign_q, rsign_d;
   logic [WIDTH-1:0]   r1_q, r1_d;
   logic [WIDTH-1:0]   r2_q, r2_d;

   logic               sgn, s1, s2;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh, div_df;
   logic [2*WIDTH-1:0] mul_nxt, div_nxt, acc_nxt, prod_fix;
   logic [WIDTH-1:0]   q_fix, r_fix;

   // acc holds {partial, multiplier} for MUL and {remainder, dividend} for DIV;
   // b holds the multiplicand or the divisor.
   always_comb begin
      sgn   = ~MCycleOp[0];
      s1    = sgn & Operand1[WIDTH-1];
      s2    = sgn & Operand2[WIDTH-1];
      a_abs = s1 ? -Operand1 : Operand1;
      b_abs = s2 ? -Operand2 : Operand2;

      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + ({(WIDTH+1){acc_q[0]}} & {1'b0, b_q});
      mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

      div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_df  = div_sh - {1'b0, b_q};
      div_nxt = div_df[WIDTH]
              ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
              : {div_df[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

      acc_nxt  = op_q[1] ? div_nxt : mul_nxt;
      prod_fix = neg_q ? -acc_nxt : acc_nxt;
      q_fix    = neg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
      r_fix    = rsign_q ? -acc_nxt[2*WIDTH-1:WIDTH]
                         : acc_nxt[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      acc_d   = acc_q;
      b_d     = b_q;
      raw1_d  = raw1_q;
      neg_d   = neg_q;
      rsign_d = rsign_q;
      r1_d    = r1_q;
      r2_d    = r2_q;
      Busy    = 1'b0;
      Done    = 1'b0;

      unique case (state_q)
         IDLE: begin
            Busy = Start;
            if (Start) begin
               op_d    = MCycleOp;
               acc_d   = {{WIDTH{1'b0}}, MCycleOp[1] ? a_abs : b_abs};
               b_d     = MCycleOp[1] ? b_abs : a_abs;
               raw1_d  = Operand1;
               neg_d   = s1 ^ s2;
               rsign_d = s1;
               cnt_d   = '0;
               state_d = COMPUTING;
            end
         end
         COMPUTING: begin
            Busy  = 1'b1;
            acc_d = acc_nxt;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               if (!op_q[1]) begin
                  r1_d = prod_fix[WIDTH-1:0];
                  r2_d = prod_fix[2*WIDTH-1:WIDTH];
               end else if (b_q == '0) begin
                  r1_d = '0;
                  r2_d = raw1_q;
               end else begin
                  r1_d = q_fix;
                  r2_d = r_fix;
               end
            end
         end
         DONE: begin
            Done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (RESET) begin
         Busy = 1'b0;
         Done = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         b_q     <= '0;
         raw1_q  <= '0;
         neg_q   <= 1'b0;
         rsign_q <= 1'b0;
         r1_q    <= '0;
         r2_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         raw1_q  <= raw1_d;
         neg_q   <= neg_d;
         rsign_q <= rsign_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
      end
   end

   assign Result1 = r1_q;
   assign Result2 = r2_q;

endmodule
